// File: rtl/pipe_dem.sv
// D->E->M pipeline registers with bubble insertion (stall) and whole-pipe freeze (hold); 1-cycle per stage.
// Optional bubble counter enabled by defining PIPE_PERF_EN; otherwise bubble_cnt is tied to 0.
module pipe_dem (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        hold,
    input  logic [31:0] Dpc,
    input  logic [31:0] Dinstr,
    input  logic [31:0] Drs_data,
    input  logic [31:0] Drt_data,
    input  logic [4:0]  Dwreg,
    input  logic        DGRFwen,
    input  logic [1:0]  DGRFwdst,
    input  logic [1:0]  Dtnew,
    input  logic [31:0] Eres,
    output logic [31:0] Epc,
    output logic [31:0] Einstr,
    output logic [31:0] Ers_data,
    output logic [31:0] Ert_data,
    output logic [4:0]  Ewreg,
    output logic        EGRFwen,
    output logic [1:0]  EGRFwdst,
    output logic [1:0]  Etnew,
    output logic [31:0] Mpc,
    output logic [31:0] Minstr,
    output logic [31:0] Mres,
    output logic [31:0] Mrt_data,
    output logic [4:0]  Mwreg,
    output logic        MGRFwen,
    output logic [1:0]  MGRFwdst,
    output logic [1:0]  Mtnew,
    output logic [31:0] bubble_cnt
);

    logic [31:0] r_Epc, r_Einstr, r_Ers_data, r_Ert_data;
    logic [4:0]  r_Ewreg;
    logic        r_EGRFwen;
    logic [1:0]  r_EGRFwdst, r_Etnew;
    logic [31:0] r_Mpc, r_Minstr, r_Mres, r_Mrt_data;
    logic [4:0]  r_Mwreg;
    logic        r_MGRFwen;
    logic [1:0]  r_MGRFwdst, r_Mtnew;
    logic [1:0]  w_Dtnew_dec, w_Etnew_dec;

    // tnew counts down by one per stage and never wraps below zero
    assign w_Dtnew_dec = (Dtnew == 2'd0) ? 2'd0 : Dtnew - 2'd1;
    assign w_Etnew_dec = (r_Etnew == 2'd0) ? 2'd0 : r_Etnew - 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_Epc      <= 32'd0;
            r_Einstr   <= 32'd0;
            r_Ers_data <= 32'd0;
            r_Ert_data <= 32'd0;
            r_Ewreg    <= 5'd0;
            r_EGRFwen  <= 1'b0;
            r_EGRFwdst <= 2'd0;
            r_Etnew    <= 2'd0;
            r_Mpc      <= 32'd0;
            r_Minstr   <= 32'd0;
            r_Mres     <= 32'd0;
            r_Mrt_data <= 32'd0;
            r_Mwreg    <= 5'd0;
            r_MGRFwen  <= 1'b0;
            r_MGRFwdst <= 2'd0;
            r_Mtnew    <= 2'd0;
        end else if (!hold) begin
            r_Mpc      <= r_Epc;
            r_Minstr   <= r_Einstr;
            r_Mres     <= Eres;
            r_Mrt_data <= r_Ert_data;
            r_Mwreg    <= r_Ewreg;
            r_MGRFwen  <= r_EGRFwen;
            r_MGRFwdst <= r_EGRFwdst;
            r_Mtnew    <= w_Etnew_dec;
            if (stall) begin
                r_Epc      <= 32'd0;
                r_Einstr   <= 32'd0;
                r_Ers_data <= 32'd0;
                r_Ert_data <= 32'd0;
                r_Ewreg    <= 5'd0;
                r_EGRFwen  <= 1'b0;
                r_EGRFwdst <= 2'd0;
                r_Etnew    <= 2'd0;
            end else begin
                r_Epc      <= Dpc;
                r_Einstr   <= Dinstr;
                r_Ers_data <= Drs_data;
                r_Ert_data <= Drt_data;
                r_Ewreg    <= Dwreg;
                r_EGRFwen  <= DGRFwen;
                r_EGRFwdst <= DGRFwdst;
                r_Etnew    <= w_Dtnew_dec;
            end
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_bubble_cnt <= 32'd0;
        else if (stall && !hold)
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end

    assign bubble_cnt = r_bubble_cnt;
`else
    assign bubble_cnt = 32'd0;
`endif

    assign Epc      = r_Epc;
    assign Einstr   = r_Einstr;
    assign Ers_data = r_Ers_data;
    assign Ert_data = r_Ert_data;
    assign Ewreg    = r_Ewreg;
    assign EGRFwen  = r_EGRFwen;
    assign EGRFwdst = r_EGRFwdst;
    assign Etnew    = r_Etnew;
    assign Mpc      = r_Mpc;
    assign Minstr   = r_Minstr;
    assign Mres     = r_Mres;
    assign Mrt_data = r_Mrt_data;
    assign Mwreg    = r_Mwreg;
    assign MGRFwen  = r_MGRFwen;
    assign MGRFwdst = r_MGRFwdst;
    assign Mtnew    = r_Mtnew;

endmodule

// File: doc/pipe_dem.md
PIPE_DEM -- requirements
Module: pipe_dem

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 stall  input  1  D->E bubble request from hazard unit: E loads bubble, E->M advances.
REQ-004 hold  input  1  whole-pipe freeze (e.g. multicycle unit busy): E and M keep contents.
REQ-005 Dpc, Dinstr  input  32 each  D-stage PC and instruction word.
REQ-006 Drs_data, Drt_data  input  32 each  D-stage forwarded operands.
REQ-007 Dwreg  input  5  D-stage destination register.
REQ-008 DGRFwen  input  1  D-stage GRF write enable.
REQ-009 DGRFwdst  input  2  write-data source: 0 ALU result, 1 memory, 2 PC+8; 3 is reserved and passed through unchanged.
REQ-010 Dtnew  input  2  cycles until result ready, counted at D.
REQ-011 Eres  input  32  E-stage ALU result.
REQ-012 Epc, Einstr, Ers_data, Ert_data  output  32 each  E-stage register contents.
REQ-013 Ewreg 5, EGRFwen 1, EGRFwdst 2, Etnew 2  outputs  E-stage write-back descriptor.
REQ-014 Mpc, Minstr, Mres, Mrt_data  output  32 each  M-stage register contents.
REQ-015 Mwreg 5, MGRFwen 1, MGRFwdst 2, Mtnew 2  outputs  M-stage write-back descriptor.
REQ-016 bubble_cnt  output  32  inserted-bubble count (see Configuration).

Function
REQ-017 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-018 Normal advance (hold=0, stall=0): on each clk edge E SHALL load the D* inputs and M SHALL load the E* contents, with Mres<=Eres and Mrt_data<=Ert_data.
REQ-019 Etnew SHALL load Dtnew-1, saturating at 0; Mtnew SHALL load Etnew-1, saturating at 0.
REQ-020 EGRFwdst/MGRFwdst, Ewreg/Mwreg, EGRFwen/MGRFwen SHALL pass unchanged between stages.
REQ-021 stall=1, hold=0: E SHALL load a bubble; M SHALL load the prior E contents per REQ-018/019.
REQ-022 Bubble = all E fields 0: pc 0, instr 0 (nop), operands 0, wreg 0, GRFwen 0, GRFwdst 0, tnew 0.
REQ-023 hold=1: E and M SHALL retain contents, including tnew; stall is ignored that cycle.
REQ-024 Priority: reset > hold > stall > normal advance.
REQ-025 A descriptor with GRFwen=1 and wreg=0 SHALL be carried unchanged; nulling is the consumer's job.
REQ-026 Back-to-back stalls SHALL each insert exactly one bubble; a bubble reaches M one cycle later.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) force every E and M field to the bubble value of REQ-022 and bubble_cnt to 0.
REQ-028 Reset asserted mid-stall or mid-hold SHALL discard all in-flight contents; the first edge after deassertion follows REQ-024 normally.

Configuration
REQ-029 Macro PIPE_PERF_EN defined: bubble_cnt SHALL increment by 1 on each clk edge with stall=1 and hold=0, wrapping 0xFFFFFFFF->0.
REQ-030 PIPE_PERF_EN undefined: bubble_cnt SHALL be constant 0, no counter logic synthesised; all other behaviour identical.

Verification
REQ-031 Reset: assert reset between edges with E/M non-empty -> all outputs 0 before next edge.
REQ-032 Advance: Dwreg=5, DGRFwen=1, DGRFwdst=2, Dtnew=2, Dpc=0x3000 -> edge1: Ewreg=5, Etnew=1, Epc=0x3000; edge2: Mwreg=5, Mtnew=0, MGRFwdst=2.
REQ-033 Stall: stall=1 for one cycle with E holding wreg=8 -> E all-zero bubble, Mwreg=8; next edge Mwreg=0, MGRFwen=0.
REQ-034 Hold: hold=1 and stall=1 for 3 cycles -> E/M unchanged incl. Etnew=1; bubble_cnt unchanged; after release, advance resumes.
REQ-035 Saturation: Dtnew=0 -> Etnew=0, then Mtnew=0.
REQ-036 Counter (PIPE_PERF_EN): preload via 0xFFFFFFFF stalls or forced state, one more stall -> bubble_cnt=0; without macro bubble_cnt=0 throughout.
